// File: rtl/instr_issue.sv
// Instruction issue buffer: circular FIFO between fetch and decode, with an
// optional branch stall/flush controller enabled by ISSUE_BRANCH_STALL_EN.
module instr_issue #(
  parameter int          DEPTH     = 4,
  parameter logic [5:0]  BRANCH_OP = 6'b000100,
  localparam int         AW        = $clog2(DEPTH),
  localparam int         CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_opcode,
  output logic [31:0]   out_instr,
  input  logic          br_resolve,
  input  logic          br_flush,
  output logic [CW-1:0] count,
  output logic          dbg_wait_br_o
);

  // Handshake: a transfer happens on a port in any cycle where its valid and
  // ready are both high at the rising edge; valid never depends on ready.

`ifdef ISSUE_BRANCH_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic {
    ISSUE   = 1'b0,
    WAIT_BR = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    mem_q [DEPTH];

  logic push, pop;
  logic flush_req;
  logic flush_clr;
  logic resolve;

  // A taken-branch flush blocks fetch immediately; it only clears the queue
  // while a branch is actually outstanding.
  assign flush_req = STALL_EN && br_resolve && br_flush;
  assign resolve   = STALL_EN && br_resolve;
  assign flush_clr = flush_req && (state_q == WAIT_BR);

  assign in_ready  = (count_q < CW'(DEPTH)) && !flush_req;
  assign out_valid = (count_q != '0) && (state_q == ISSUE);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr     = mem_q[rd_ptr_q];
  assign out_opcode    = out_instr[31:26];
  assign count         = count_q;
  assign dbg_wait_br_o = (state_q == WAIT_BR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE: begin
        if (STALL_EN && pop && (out_opcode == BRANCH_OP)) state_d = WAIT_BR;
      end
      WAIT_BR: begin
        if (resolve) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ISSUE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

endmodule
